// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED array row scanner.
package led_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANKING,
    SHOW
  } scan_state_t;

  localparam int FRAME_W  = 36;
  localparam int ROW_W    = 4;
  localparam int NUM_ROWS = 8;
  localparam logic [ROW_W-1:0] LAST_ROW = 4'd7;

  // Timer must hold the larger of DWELL-1 and BLANK-1; never narrower than 1 bit.
  function automatic int timer_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/led_scan_controller_scan_timer.sv
// Loadable down-counter shared by the blanking and show phases; load wins over run.
module scan_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/led_scan_controller.sv
// Row scanner for the 8-row LED array: blank/show sequencing, double-buffered
// frame with valid/ready load and tear-free swap at the end of row 7.
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int DWELL = 1024,
  parameter int BLANK = 16
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               enable,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic [FRAME_W-1:0] frame_out,
  output logic [ROW_W-1:0]   COUNT,
  output logic               blank,
  output logic               frame_start,
  output logic               swap_done,
  output scan_state_t        state
);

  localparam int TW = timer_width(DWELL, BLANK);
  localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK - 1);
  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL - 1);

  // Handshake: a frame transfers on any edge where frame_valid and frame_ready
  // are both high; frame_ready is itself the shadow-empty flag, and the source
  // must hold frame_in/frame_valid while frame_ready is low.
  logic [FRAME_W-1:0] shadow;
  logic               tmr_load;
  logic               tmr_run;
  logic               tmr_zero;
  logic [TW-1:0]      tmr_val;

  scan_timer #(.W(TW)) u_timer (
    .clk      (CLOCK),
    .rst_n    (RESET),
    .load     (tmr_load),
    .load_val (tmr_val),
    .run      (tmr_run),
    .zero     (tmr_zero)
  );

  // Timer is reloaded on every state change so it never under-runs.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_run  = (state != IDLE);
    case (state)
      IDLE: begin
        if (enable) begin
          tmr_load = 1'b1;
          tmr_val  = BLANK_LOAD;
        end
      end
      BLANKING: begin
        if (!enable) begin
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = DWELL_LOAD;
        end
      end
      SHOW: begin
        if (!enable) begin
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = BLANK_LOAD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      COUNT       <= '0;
      blank       <= 1'b1;
      frame_out   <= '0;
      frame_ready <= 1'b1;
      shadow      <= '0;
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
      if (frame_valid && frame_ready) begin
        shadow      <= frame_in;
        frame_ready <= 1'b0;
      end
      case (state)
        IDLE: begin
          blank <= 1'b1;
          COUNT <= '0;
          if (enable) state <= BLANKING;
        end
        BLANKING: begin
          if (!enable) begin
            state <= IDLE;
            COUNT <= '0;
            blank <= 1'b1;
          end else if (tmr_zero) begin
            state       <= SHOW;
            blank       <= 1'b0;
            frame_start <= (COUNT == '0);
          end
        end
        SHOW: begin
          if (!enable) begin
            state <= IDLE;
            COUNT <= '0;
            blank <= 1'b1;
          end else if (tmr_zero) begin
            state <= BLANKING;
            blank <= 1'b1;
            if (COUNT == LAST_ROW) begin
              COUNT <= '0;
              // A frame accepted on this same edge sees frame_ready=1 here and waits a frame.
              if (!frame_ready) begin
                frame_out   <= shadow;
                frame_ready <= 1'b1;
                swap_done   <= 1'b1;
              end
            end else begin
              COUNT <= COUNT + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller with DWELL=4, BLANK=2 (row period 6, frame period 48).
module tb_led_scan_controller;
  import led_scan_pkg::*;

  localparam int DWELL = 4;
  localparam int BLANK = 2;

  logic               CLOCK = 1'b0;
  logic               RESET = 1'b0;
  logic               enable = 1'b0;
  logic [FRAME_W-1:0] frame_in = '0;
  logic               frame_valid = 1'b0;
  logic               frame_ready;
  logic [FRAME_W-1:0] frame_out;
  logic [ROW_W-1:0]   COUNT;
  logic               blank;
  logic               frame_start;
  logic               swap_done;
  scan_state_t        state;

  led_scan_controller #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .enable      (enable),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_out   (frame_out),
    .COUNT       (COUNT),
    .blank       (blank),
    .frame_start (frame_start),
    .swap_done   (swap_done),
    .state       (state)
  );

  // ---------------- clock / reset / cycle index ----------------
  always #5 CLOCK = ~CLOCK;

  int cyc;
  always @(posedge CLOCK or negedge RESET) begin
    if (!RESET) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0]         trace_q[$];    // {COUNT, blank, frame_start} per cycle
  int                 swap_cyc_q[$];
  logic [FRAME_W-1:0] swap_dat_q[$];
  int                 acc_q[$];
  logic [FRAME_W-1:0] exp_out = '0;

  task automatic check(input string name, input logic [FRAME_W-1:0] act,
                       input logic [FRAME_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  task automatic push_row(input int r, input int n);
    logic [5:0] v;
    for (int i = 0; i < n; i++) begin
      v = {4'(r), 1'(i < 2), 1'(i == 2 && r == 0)};
      trace_q.push_back(v);
    end
  endtask

  task automatic push_frame();
    for (int r = 0; r < NUM_ROWS; r++) push_row(r, 6);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) trace_q.push_back(6'b0000_1_0);
  endtask

  task automatic push_swap(input int c, input logic [FRAME_W-1:0] d);
    swap_cyc_q.push_back(c);
    swap_dat_q.push_back(d);
  endtask

  // ---------------- monitor ----------------
  logic [5:0] mon_t;
  logic       mon_swap;
  logic       mon_acc;

  always @(negedge CLOCK) begin
    if (!RESET) begin
      exp_out = '0;
    end else begin
      if (trace_q.size() > 0) begin
        mon_t = trace_q.pop_front();
        check("row_trace", {COUNT, blank, frame_start}, mon_t);
      end
      mon_swap = (swap_cyc_q.size() > 0) && (swap_cyc_q[0] == cyc);
      if (mon_swap) begin
        exp_out = swap_dat_q.pop_front();
        void'(swap_cyc_q.pop_front());
      end
      check("swap_done", swap_done, mon_swap);
      check("frame_out", frame_out, exp_out);
      if (swap_done) check("ready_after_swap", frame_ready, 1'b1);
      mon_acc = (acc_q.size() > 0) && (acc_q[0] == cyc);
      if (mon_acc) void'(acc_q.pop_front());
      check("accept", frame_valid && frame_ready, mon_acc);
    end
  end

  // ---------------- driver ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic send(input int at, input logic [FRAME_W-1:0] d);
    wait_cyc(at);
    frame_in    = d;
    frame_valid = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blank"}, blank, 1'b1);
    check({tag, "_count"}, COUNT, '0);
    check({tag, "_frame_out"}, frame_out, '0);
    check({tag, "_ready"}, frame_ready, 1'b1);
    check({tag, "_frame_start"}, frame_start, 1'b0);
    check({tag, "_swap_done"}, swap_done, 1'b0);
    check({tag, "_state"}, state, IDLE);
  endtask

  initial begin
    RESET  = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    check_reset_outputs("reset");

    // Expected row trace: continuous scan, enable drop in row 5 SHOW, restart, reset in row 1 SHOW.
    push_idle(1);
    repeat (4) push_frame();
    for (int r = 0; r < 5; r++) push_row(r, 6);
    push_row(5, 4);
    push_idle(4);
    push_frame();
    push_row(0, 6);
    push_row(1, 3);

    push_swap(49,  36'hF_0000_00FF);
    push_swap(97,  36'h0_1234_5678);
    push_swap(193, 36'hA_5A5A_C3C3);
    push_swap(279, 36'h5_DEAD_BEEF);
    acc_q.push_back(13);
    acc_q.push_back(49);
    acc_q.push_back(144);
    acc_q.push_back(200);
    acc_q.push_back(281);

    @(posedge CLOCK);
    #1;
    RESET = 1'b1;

    send(13, 36'hF_0000_00FF);       // row 2
    wait_cyc(14); frame_valid = 1'b0;
    send(20, 36'h0_1234_5678);       // held against a full shadow
    wait_cyc(50); frame_valid = 1'b0;
    send(144, 36'hA_5A5A_C3C3);      // last SHOW cycle of row 7
    wait_cyc(145); frame_valid = 1'b0;
    send(200, 36'h5_DEAD_BEEF);
    wait_cyc(201); frame_valid = 1'b0;
    wait_cyc(226); enable = 1'b0;    // row 5 SHOW
    wait_cyc(230); enable = 1'b1;
    send(281, 36'h0_0F0F_0F0F);
    wait_cyc(282); frame_valid = 1'b0;

    wait_cyc(288);
    #2;
    RESET = 1'b0;
    #1;
    check_reset_outputs("async_reset");

    // Pending shadow frame must be gone: one full frame with no swap.
    push_idle(1);
    push_frame();
    push_row(0, 6);
    repeat (2) @(posedge CLOCK);
    #1;
    RESET = 1'b1;
    wait_cyc(60);

    check("trace_drained", 36'(trace_q.size()), '0);
    check("swaps_drained", 36'(swap_cyc_q.size()), '0);
    check("accepts_drained", 36'(acc_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
